// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// ---------------------------------------------------------------------------
// Serial-to-parallel frame receiver. Samples din once per clk, detects a
// start bit (1), assembles WIDTH data bits LSB-first, optionally checks an
// even-parity bit, then checks the stop bit (expected 0). Each completed
// frame is presented on a valid/ready output register together with its
// error flags.
//
// Parameters:
//   WIDTH      data bits per frame (2..32)
//   PARITY_EN  1 = an even-parity bit follows the data, 0 = no parity bit
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   din        serial input, idle level 0
//   out_data   received word, bit 0 = first data bit received
//   out_valid  out_data/par_err/frm_err hold a word
//   out_ready  consumer takes the word when out_valid & out_ready at an edge
//   par_err    parity mismatch for the presented word
//   frm_err    stop bit was 1 for the presented word
//   overrun    sticky: a completed frame was dropped (output register full)
//   busy       receiver is inside a frame
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_data and the
// flags do not change. out_valid never drops without a transfer.
// ---------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             par_err,
    output logic             frm_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_pend;
    logic             last_bit;
    logic             out_free;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // The output register can take a new word if it is empty or is being
    // emptied on this very edge.
    assign out_free = !out_valid || out_ready;
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. STOP always returns to IDLE, so a stop bit of 1 is
    // never taken as the start of the next frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (din) state_nxt = DATA;
            DATA:    if (last_bit) state_nxt = PARITY_EN ? PARITY : STOP;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Assembly datapath and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            shreg     <= '0;
            par_pend  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (din) cnt <= '0;
                end
                DATA: begin
                    shreg[cnt] <= din;
                    cnt        <= cnt + 1'b1;
                end
                PARITY: begin
                    // Even parity: data bits plus parity bit XOR to 0.
                    par_pend <= din ^ (^shreg);
                end
                default: ;
            endcase

            if (state == STOP) begin
                if (out_free) begin
                    out_data  <= shreg;
                    par_err   <= PARITY_EN ? par_pend : 1'b0;
                    frm_err   <= din;
                    out_valid <= 1'b1;
                end else begin
                    // Held word is kept; the new frame is lost.
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    localparam int W = 8;
    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_DONE  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         par_err;
    logic         frm_err;
    logic         overrun;
    logic         busy;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .par_err   (par_err),
        .frm_err   (frm_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // ---------------- scoreboard / reference model ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // Frame-level model of the output port
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic         m_par   = 1'b0;
    logic         m_frm   = 1'b0;
    logic         m_ovr   = 1'b0;
    logic         m_busy  = 1'b0;

    // Frame currently on the wire
    logic [W-1:0] cur_data;
    logic         cur_par_err;
    logic         cur_frm;

    logic [W-1:0] p_data = '0;

    logic rdy_fixed = 1'b1;
    bit   rdy_rand  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic next_rdy();
        if (rdy_rand) return logic'($urandom_range(0, 1));
        return rdy_fixed;
    endfunction

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic tick(input logic d, input logic r, input int ev);
        logic acc;
        din       = d;
        out_ready = r;
        @(posedge clk);
        acc = m_valid && r;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_par   = 1'b0;
            m_frm   = 1'b0;
            m_ovr   = 1'b0;
            m_busy  = 1'b0;
            exp_q.delete();
        end else begin
            if (acc) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("sb_word", 32'(p_data), 32'(exp_q.pop_front()));
            end
            if (ev == EV_START) m_busy = 1'b1;
            if (ev == EV_DONE) begin
                m_busy = 1'b0;
                if (!m_valid || r) begin
                    m_valid = 1'b1;
                    m_data  = cur_data;
                    m_par   = cur_par_err;
                    m_frm   = cur_frm;
                    exp_q.push_back(cur_data);
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (acc) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("par_err", 32'(par_err), 32'(m_par));
            check("frm_err", 32'(frm_err), 32'(m_frm));
        end
        if (rst) check("out_data_rst", 32'(out_data), 32'd0);
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("busy", 32'(busy), 32'(m_busy));
        p_data = out_data;
    endtask

    // ---------------- driver tasks ----------------
    // stop_rdy < 0 : out_ready on the stop edge follows the normal policy
    task automatic send_frame(input logic [W-1:0] data, input logic pbit,
                              input logic sbit, input int stop_rdy);
        cur_data    = data;
        cur_par_err = pbit ^ (^data);
        cur_frm     = sbit;
        tick(1'b1, next_rdy(), EV_START);
        for (int i = 0; i < W; i++) tick(data[i], next_rdy(), EV_NONE);
        tick(pbit, next_rdy(), EV_NONE);
        tick(sbit, (stop_rdy < 0) ? next_rdy() : logic'(stop_rdy[0]), EV_DONE);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, next_rdy(), EV_NONE);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, next_rdy(), EV_NONE);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] d;
        logic         pb;
        logic         sb;

        rst = 1'b1;
        tick(1'b0, 1'b0, EV_NONE);
        tick(1'b0, 1'b0, EV_NONE);
        rst = 1'b0;

        // Clean 0xA5, ready held high
        rdy_fixed = 1'b1;
        idle(1);
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        idle(2);

        // Parity error, then clean 0x3C back-to-back
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        idle(2);

        // Framing error followed by quiet line
        send_frame(8'h0F, 1'b0, 1'b1, -1);
        idle(3);

        // Stall and overrun
        rdy_fixed = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b0, 1'b0, -1);
        idle(2);
        tick(1'b0, 1'b1, EV_NONE);
        idle(2);
        do_reset();

        // Accept and completion on the same edge
        send_frame(8'h11, 1'b0, 1'b0, -1);
        idle(1);
        send_frame(8'h22, 1'b0, 1'b0, 1);
        idle(2);
        tick(1'b0, 1'b1, EV_NONE);
        idle(1);

        // Reset in the middle of a frame, then a clean 0x5A
        rdy_fixed = 1'b1;
        tick(1'b1, 1'b1, EV_START);
        for (int i = 0; i < 4; i++) tick(logic'($urandom_range(0, 1)), 1'b1, EV_NONE);
        do_reset();
        send_frame(8'h5A, 1'b0, 1'b0, -1);
        idle(2);

        // Random frames, random gaps, random consumer stalls
        do_reset();
        rdy_rand = 1'b1;
        for (int f = 0; f < 60; f++) begin
            d  = W'($urandom);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 5) == 0);
            send_frame(d, pb, sb, -1);
            idle($urandom_range(0, 2));
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial-to-parallel frame receiver that consumes the 1-bit stream produced by the 4-stage serial shift register (its Q output drives `din`). It samples one bit per `clk`, detects a start bit, assembles a WIDTH-bit word LSB-first, and checks even parity and the stop bit. It presents each word with error flags on a valid/ready output port. Overruns are flagged when the consumer stalls.

## Interface
- WIDTH, 8: data bits per frame (2..32).
- PARITY_EN, 1: 1 = frame carries an even-parity bit after the data; 0 = no parity bit, and par_err is held 0.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  1  serial stream; idle level 0.
- out_data  output  WIDTH  received word (bit 0 = first data bit received).
- out_valid  output  1  out_data and the flags are valid.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready at a rising edge.
- par_err  output  1  parity mismatch for the presented word; qualified by out_valid.
- frm_err  output  1  stop bit was 1 for the presented word; qualified by out_valid.
- overrun  output  1  sticky; a completed frame was dropped because the output register was full.
- busy  output  1  receiver is inside a frame (state != IDLE).

## Operation
- Frame format on din: start bit 1, then WIDTH data bits LSB-first, then a parity bit (only if PARITY_EN), then stop bit 0.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: din=1 → DATA, bit counter cleared. din=0 → stay in IDLE.
  - DATA: shift din into position cnt of the assembly register, then cnt++. After WIDTH bits → PARITY if PARITY_EN, else STOP.
  - PARITY: capture the parity error as din != XOR-reduce(assembly register) → STOP.
  - STOP: capture frm_err = din, complete the frame, → IDLE.
- A stop bit of 1 is consumed as the stop bit. It is never reinterpreted as a start bit.
- Frame completion happens on the STOP-cycle edge:
  - If the output register is empty, or is being accepted on that same edge (out_valid & out_ready): load out_data/par_err/frm_err and keep out_valid=1.
  - Otherwise the new frame is discarded, the held word is kept unchanged, and overrun is set.
- Accept without a completion on the same edge: out_valid → 0. out_data and the flags hold their last values.
- Errored frames are still delivered, with their flags set.
- overrun is cleared only by rst.
- Reset values: state=IDLE, cnt=0, assembly register=0, out_data=0, out_valid=0, par_err=0, frm_err=0, overrun=0, busy=0.
- rst has priority over every other event, including in the middle of a frame. A partial frame is discarded and produces no output.

## Timing
- Let the start bit be sampled at edge k (PARITY_EN=1):
  - data bits are sampled at edges k+1..k+WIDTH;
  - the parity bit at k+WIDTH+1;
  - the stop bit at k+WIDTH+2.
- out_valid is high from edge k+WIDTH+2 onward. Latency from start bit to valid is WIDTH+2 cycles (WIDTH+1 with PARITY_EN=0).
- busy is high from edge k until the STOP edge.
- Back-to-back frames are supported: a start bit on the cycle right after the stop bit is accepted. The minimum frame period is WIDTH+3 cycles (WIDTH+2 with PARITY_EN=0).
- The output port is valid/ready. out_data and the flags are stable while out_valid=1 and out_ready=0.
- No combinational path from din or out_ready to any output. All outputs are registered.

## Test plan
- Clean frame (WIDTH=8, PARITY_EN=1), out_ready=1. Drive din = 1, then 1,0,1,0,0,1,0,1, then 0 (parity), then 0 (stop). Required: out_data=0xA5, par_err=0, frm_err=0, out_valid high exactly 10 edges after the start edge, and for exactly one cycle.
- Parity error: same stream with the parity bit set to 1. Required: out_data=0xA5, par_err=1, frm_err=0. Then a clean 0x3C frame immediately after the stop bit must yield 0x3C with both flags 0.
- Framing error: 0x0F frame with stop=1, followed by din=0 for 3 cycles. Required: out_data=0x0F, frm_err=1. No second frame is started by the stop bit, and busy=0 after the stop edge.
- Stall and overrun: out_ready=0, send 0x11 then 0x22 back-to-back. Required: out_data stays 0x11 with out_valid=1, and overrun=1 after the second stop edge. Then assert out_ready for one cycle. Required: out_valid→0 and overrun stays 1.
- Simultaneous accept and completion: hold 0x11 with out_valid=1, and pulse out_ready on the exact stop edge of frame 0x22. Required: out_data=0x22, out_valid stays 1, overrun stays 0.
- Reset mid-frame: assert rst after 4 data bits, then send a clean 0x5A frame. Required: all outputs are 0 the cycle after rst, and only 0x5A is delivered.
